// File: rtl/digital_pll_sequencer.sv
// Bring-up and lock-supervision controller for the on-chip digital PLL.
// Sequences PLL reset/enable, verifies frequency lock by counting feedback toggles per window.
module digital_pll_sequencer #(
    parameter int HOLD_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 1024,
    parameter int WINDOW        = 256,
    parameter int FB_SHIFT      = 4,
    parameter int TOL           = 2,
    parameter int MAX_RETRY     = 3
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        start,
    input  logic        stop,
    input  logic [4:0]  cfg_div,
    input  logic        cfg_dco,
    input  logic [25:0] cfg_trim,
    input  logic        fb_toggle,
    output logic        pll_resetb,
    output logic        pll_enable,
    output logic        pll_dco,
    output logic [4:0]  pll_div,
    output logic [25:0] pll_ext_trim,
    output logic        locked,
    output logic        fault,
    output logic        busy,
    output logic [9:0]  last_count
);
    localparam int TMAX = (HOLD_CYCLES > SETTLE_CYCLES) ?
                          ((HOLD_CYCLES > WINDOW) ? HOLD_CYCLES : WINDOW) :
                          ((SETTLE_CYCLES > WINDOW) ? SETTLE_CYCLES : WINDOW);
    localparam int TW = $clog2(TMAX);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] HOLD_END   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_END = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] WIN_END    = TW'(WINDOW - 1);
    localparam logic [RW-1:0] RETRY_END  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    state_t          state_r, state_n;
    logic [TW-1:0]   timer_r, timer_n;
    logic [9:0]      edge_cnt_r, edge_cnt_n, count_s;
    logic [9:0]      last_count_r, last_count_n;
    logic [9:0]      exp_r, exp_s;
    logic [RW-1:0]   retry_r, retry_n, retry_inc_s;
    logic            miss_r, miss_n;
    logic            latch_s, in_tol_s, edge_s;
    logic [2:0]      fb_sync_r;
    logic [4:0]      div_r;
    logic            dco_r;
    logic [25:0]     trim_r;
    logic            pll_resetb_r, pll_enable_r, locked_r, fault_r, busy_r;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Each level change of the synchronized feedback is one edge; the window count saturates.
    assign edge_s      = fb_sync_r[2] ^ fb_sync_r[1];
    assign count_s     = (edge_s && (edge_cnt_r != 10'h3FF)) ? (edge_cnt_r + 10'd1) : edge_cnt_r;
    assign in_tol_s    = (abs_diff(count_s, exp_r) <= 10'(TOL));
    assign retry_inc_s = retry_r + RW'(1);
    assign exp_s       = 10'((32'(cfg_div) * 32'(WINDOW)) >> FB_SHIFT);

    // Two-flop synchronizer plus one edge-detect stage for the asynchronous feedback toggle
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            fb_sync_r <= 3'b000;
        end else begin
            fb_sync_r <= {fb_sync_r[1:0], fb_toggle};
        end
    end

    // Sequencer next state plus timer, window, retry and miss bookkeeping
    always_comb begin
        state_n      = state_r;
        timer_n      = timer_r;
        edge_cnt_n   = edge_cnt_r;
        retry_n      = retry_r;
        miss_n       = miss_r;
        last_count_n = last_count_r;
        latch_s      = 1'b0;
        if (stop) begin
            state_n    = ST_IDLE;
            timer_n    = {TW{1'b0}};
            edge_cnt_n = 10'd0;
            retry_n    = {RW{1'b0}};
            miss_n     = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_FAULT: begin
                    if (start) begin
                        latch_s    = 1'b1;
                        timer_n    = {TW{1'b0}};
                        edge_cnt_n = 10'd0;
                        miss_n     = 1'b0;
                        if ((cfg_div < 5'd2) && !cfg_dco) begin
                            state_n = ST_FAULT;
                        end else begin
                            retry_n = {RW{1'b0}};
                            state_n = ST_HOLD;
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_HOLD: begin
                    if (timer_r == HOLD_END) begin
                        state_n = ST_SETTLE;
                        timer_n = {TW{1'b0}};
                    end else begin
                        timer_n = timer_r + TW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (timer_r == SETTLE_END) begin
                        timer_n    = {TW{1'b0}};
                        edge_cnt_n = 10'd0;
                        state_n    = dco_r ? ST_LOCKED : ST_MEASURE;
                    end else begin
                        timer_n = timer_r + TW'(1);
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if ((state_r == ST_LOCKED) && dco_r) begin
                        state_n = ST_LOCKED;
                    end else if (timer_r == WIN_END) begin
                        // Window closes: an edge on this last cycle still belongs to it
                        timer_n      = {TW{1'b0}};
                        edge_cnt_n   = 10'd0;
                        last_count_n = count_s;
                        if (in_tol_s) begin
                            state_n = ST_LOCKED;
                            retry_n = {RW{1'b0}};
                            miss_n  = 1'b0;
                        end else if (state_r == ST_MEASURE) begin
                            retry_n = retry_inc_s;
                            state_n = (retry_inc_s == RETRY_END) ? ST_FAULT : ST_HOLD;
                        end else if (miss_r) begin
                            state_n = ST_HOLD;
                            retry_n = {RW{1'b0}};
                            miss_n  = 1'b0;
                        end else begin
                            miss_n = 1'b1;
                        end
                    end else begin
                        timer_n    = timer_r + TW'(1);
                        edge_cnt_n = count_s;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // State register and sequencing counters
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_r      <= ST_IDLE;
            timer_r      <= {TW{1'b0}};
            edge_cnt_r   <= 10'd0;
            retry_r      <= {RW{1'b0}};
            miss_r       <= 1'b0;
            last_count_r <= 10'd0;
        end else begin
            state_r      <= state_n;
            timer_r      <= timer_n;
            edge_cnt_r   <= edge_cnt_n;
            retry_r      <= retry_n;
            miss_r       <= miss_n;
            last_count_r <= last_count_n;
        end
    end

    // Configuration captured on an accepted start, dropped when returning to IDLE
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            div_r  <= 5'd0;
            dco_r  <= 1'b0;
            trim_r <= 26'd0;
            exp_r  <= 10'd0;
        end else if (stop) begin
            div_r  <= 5'd0;
            dco_r  <= 1'b0;
            trim_r <= 26'd0;
            exp_r  <= 10'd0;
        end else if (latch_s) begin
            div_r  <= cfg_div;
            dco_r  <= cfg_dco;
            trim_r <= cfg_trim;
            exp_r  <= exp_s;
        end
    end

    // Registered PLL controls and status; locked lags entry into LOCKED by one cycle
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            pll_enable_r <= 1'b0;
            pll_resetb_r <= 1'b0;
            busy_r       <= 1'b0;
            fault_r      <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            pll_enable_r <= (state_n == ST_HOLD) || (state_n == ST_SETTLE) ||
                            (state_n == ST_MEASURE) || (state_n == ST_LOCKED);
            pll_resetb_r <= (state_n == ST_SETTLE) || (state_n == ST_MEASURE) ||
                            (state_n == ST_LOCKED);
            busy_r       <= (state_n == ST_HOLD) || (state_n == ST_SETTLE) ||
                            (state_n == ST_MEASURE);
            fault_r      <= (state_n == ST_FAULT);
            locked_r     <= (state_r == ST_LOCKED) && (state_n == ST_LOCKED);
        end
    end

    assign pll_resetb   = pll_resetb_r;
    assign pll_enable   = pll_enable_r;
    assign pll_dco      = dco_r;
    assign pll_div      = div_r;
    assign pll_ext_trim = trim_r;
    assign locked       = locked_r;
    assign fault        = fault_r;
    assign busy         = busy_r;
    assign last_count   = last_count_r;

endmodule

// File: tb/tb_digital_pll_sequencer.sv
// Self-checking bench for digital_pll_sequencer: directed scenarios plus a randomized
// window-count sequence checked against a window-level lock/retry model.
module tb_digital_pll_sequencer;
    logic        clock = 1'b0;
    logic        resetb;
    logic        start;
    logic        stop;
    logic [4:0]  cfg_div;
    logic        cfg_dco;
    logic [25:0] cfg_trim;
    logic        fb_toggle;
    logic        pll_resetb;
    logic        pll_enable;
    logic        pll_dco;
    logic [4:0]  pll_div;
    logic [25:0] pll_ext_trim;
    logic        locked;
    logic        fault;
    logic        busy;
    logic [9:0]  last_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    digital_pll_sequencer dut (
        .clock(clock), .resetb(resetb), .start(start), .stop(stop),
        .cfg_div(cfg_div), .cfg_dco(cfg_dco), .cfg_trim(cfg_trim), .fb_toggle(fb_toggle),
        .pll_resetb(pll_resetb), .pll_enable(pll_enable), .pll_dco(pll_dco),
        .pll_div(pll_div), .pll_ext_trim(pll_ext_trim), .locked(locked),
        .fault(fault), .busy(busy), .last_count(last_count)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic pulse_start(input logic [4:0] d, input logic dco, input logic [25:0] t);
        cfg_div  = d;
        cfg_dco  = dco;
        cfg_trim = t;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
    endtask

    // One 256-cycle window with n feedback changes placed well inside it.
    task automatic run_window(input int n, output logic lk_first);
        lk_first = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i >= 40 && i < 40 + n) fb_toggle = ~fb_toggle;
            @(negedge clock);
            if (i == 0) lk_first = locked;
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0; start = 1'b0; stop = 1'b0; cfg_div = 5'd0; cfg_dco = 1'b0;
        cfg_trim = 26'd0; fb_toggle = 1'b0;
        step(3);
        n_chk++; if (pll_enable !== 1'b0) $display("FAIL reset_enable: got %b want 0", pll_enable); else n_pass++;
        n_chk++; if (pll_resetb !== 1'b0) $display("FAIL reset_pll_resetb: got %b want 0", pll_resetb); else n_pass++;
        n_chk++; if (locked !== 1'b0 || fault !== 1'b0 || busy !== 1'b0) $display("FAIL reset_status: got l=%b f=%b b=%b want 000", locked, fault, busy); else n_pass++;
        resetb = 1'b1;
        step(2);
        n_chk++; if (last_count !== 10'd0 || pll_div !== 5'd0) $display("FAIL reset_idle: got cnt=%0d div=%0d want 0 0", last_count, pll_div); else n_pass++;
        n_chk++; if (pll_enable !== 1'b0 || busy !== 1'b0) $display("FAIL reset_idle_en: got en=%b busy=%b want 0 0", pll_enable, busy); else n_pass++;
    endtask

    task automatic test_lock();
        logic lk;
        pulse_start(5'd8, 1'b0, 26'h0);
        n_chk++; if (pll_enable !== 1'b1 || pll_resetb !== 1'b0) $display("FAIL lock_hold: got en=%b rb=%b want 1 0", pll_enable, pll_resetb); else n_pass++;
        n_chk++; if (pll_div !== 5'd8 || busy !== 1'b1) $display("FAIL lock_cfg: got div=%0d busy=%b want 8 1", pll_div, busy); else n_pass++;
        cfg_div = 5'd3;
        step(15);
        n_chk++; if (pll_resetb !== 1'b0) $display("FAIL lock_hold16: got %b want 0", pll_resetb); else n_pass++;
        step(1);
        n_chk++; if (pll_resetb !== 1'b1) $display("FAIL lock_release17: got %b want 1", pll_resetb); else n_pass++;
        step(1024);
        run_window(128, lk);
        n_chk++; if (last_count !== 10'd128) $display("FAIL lock_count: got %0d want 128", last_count); else n_pass++;
        n_chk++; if (locked !== 1'b0) $display("FAIL lock_registered: got %b want 0", locked); else n_pass++;
        run_window(128, lk);
        n_chk++; if (lk !== 1'b1) $display("FAIL lock_asserted: got %b want 1", lk); else n_pass++;
        n_chk++; if (pll_div !== 5'd8 || busy !== 1'b0) $display("FAIL lock_cfg_hold: got div=%0d busy=%b want 8 0", pll_div, busy); else n_pass++;
        pulse_stop();
        n_chk++; if (locked !== 1'b0 || pll_enable !== 1'b0 || pll_div !== 5'd0) $display("FAIL lock_stop: got l=%b en=%b div=%0d want 0 0 0", locked, pll_enable, pll_div); else n_pass++;
    endtask

    task automatic test_retry_fault();
        logic lk;
        pulse_start(5'd8, 1'b0, 26'h0);
        step(1040);
        for (int a = 0; a < 3; a++) begin
            run_window(100, lk);
            n_chk++; if (last_count !== 10'd100) $display("FAIL retry_count%0d: got %0d want 100", a, last_count); else n_pass++;
            step(1);
            if (a < 2) begin
                n_chk++; if (pll_resetb !== 1'b0 || busy !== 1'b1 || fault !== 1'b0) $display("FAIL retry_rehold%0d: got rb=%b busy=%b f=%b want 0 1 0", a, pll_resetb, busy, fault); else n_pass++;
                step(1039);
            end else begin
                n_chk++; if (fault !== 1'b1 || locked !== 1'b0 || pll_enable !== 1'b0) $display("FAIL retry_fault: got f=%b l=%b en=%b want 1 0 0", fault, locked, pll_enable); else n_pass++;
            end
        end
        pulse_stop();
        n_chk++; if (fault !== 1'b0) $display("FAIL retry_stop_clears: got %b want 0", fault); else n_pass++;
    endtask

    task automatic test_lock_loss();
        logic lk;
        pulse_start(5'd8, 1'b0, 26'h0);
        step(1040);
        run_window(128, lk);
        run_window(120, lk);
        n_chk++; if (last_count !== 10'd120) $display("FAIL loss_count: got %0d want 120", last_count); else n_pass++;
        run_window(128, lk);
        n_chk++; if (lk !== 1'b1) $display("FAIL loss_single_miss: got %b want 1", lk); else n_pass++;
        run_window(120, lk);
        n_chk++; if (lk !== 1'b1) $display("FAIL loss_good_window: got %b want 1", lk); else n_pass++;
        run_window(120, lk);
        n_chk++; if (lk !== 1'b1) $display("FAIL loss_miss_cleared: got %b want 1", lk); else n_pass++;
        step(1);
        n_chk++; if (locked !== 1'b0 || pll_resetb !== 1'b0 || busy !== 1'b1) $display("FAIL loss_drop: got l=%b rb=%b busy=%b want 0 0 1", locked, pll_resetb, busy); else n_pass++;
        pulse_stop();
    endtask

    task automatic test_dco();
        pulse_start(5'd0, 1'b1, 26'h3FFFFFF);
        n_chk++; if (pll_dco !== 1'b1 || pll_ext_trim !== 26'h3FFFFFF || pll_div !== 5'd0) $display("FAIL dco_cfg: got dco=%b trim=%h div=%0d want 1 3ffffff 0", pll_dco, pll_ext_trim, pll_div); else n_pass++;
        n_chk++; if (fault !== 1'b0 || pll_enable !== 1'b1) $display("FAIL dco_start: got f=%b en=%b want 0 1", fault, pll_enable); else n_pass++;
        step(1040);
        n_chk++; if (locked !== 1'b0) $display("FAIL dco_early: got %b want 0", locked); else n_pass++;
        step(1);
        n_chk++; if (locked !== 1'b1 || fault !== 1'b0 || pll_resetb !== 1'b1) $display("FAIL dco_locked: got l=%b f=%b rb=%b want 1 0 1", locked, fault, pll_resetb); else n_pass++;
        step(600);
        n_chk++; if (locked !== 1'b1) $display("FAIL dco_stays: got %b want 1", locked); else n_pass++;
        pulse_stop();
        n_chk++; if (pll_dco !== 1'b0 || pll_ext_trim !== 26'd0 || locked !== 1'b0 || pll_enable !== 1'b0) $display("FAIL dco_stop: got dco=%b trim=%h l=%b en=%b want 0 0 0 0", pll_dco, pll_ext_trim, locked, pll_enable); else n_pass++;
    endtask

    task automatic test_bad_div();
        logic en_seen;
        en_seen = 1'b0;
        pulse_start(5'd1, 1'b0, 26'h0);
        n_chk++; if (fault !== 1'b1) $display("FAIL baddiv_fault: got %b want 1", fault); else n_pass++;
        for (int i = 0; i < 50; i++) begin
            en_seen = en_seen | pll_enable;
            @(negedge clock);
        end
        n_chk++; if (en_seen !== 1'b0) $display("FAIL baddiv_enable: got %b want 0", en_seen); else n_pass++;
        pulse_start(5'd8, 1'b0, 26'h0);
        n_chk++; if (fault !== 1'b0 || pll_enable !== 1'b1 || busy !== 1'b1) $display("FAIL baddiv_restart: got f=%b en=%b busy=%b want 0 1 1", fault, pll_enable, busy); else n_pass++;
        pulse_stop();
    endtask

    task automatic test_stop_reset();
        cfg_div = 5'd8; cfg_dco = 1'b0; start = 1'b1; stop = 1'b1;
        @(negedge clock);
        start = 1'b0; stop = 1'b0;
        step(2);
        n_chk++; if (busy !== 1'b0 || pll_enable !== 1'b0 || pll_div !== 5'd0) $display("FAIL startstop_idle: got busy=%b en=%b div=%0d want 0 0 0", busy, pll_enable, pll_div); else n_pass++;
        pulse_start(5'd8, 1'b0, 26'h0);
        step(1140);
        pulse_stop();
        n_chk++; if (busy !== 1'b0 || pll_enable !== 1'b0 || pll_resetb !== 1'b0 || pll_div !== 5'd0 || locked !== 1'b0) $display("FAIL stop_measure: got busy=%b en=%b rb=%b div=%0d l=%b want 0 0 0 0 0", busy, pll_enable, pll_resetb, pll_div, locked); else n_pass++;
        pulse_start(5'd8, 1'b0, 26'h0);
        step(200);
        n_chk++; if (pll_resetb !== 1'b1) $display("FAIL settle_pre: got %b want 1", pll_resetb); else n_pass++;
        #2 resetb = 1'b0;
        #1;
        n_chk++; if (pll_enable !== 1'b0 || pll_resetb !== 1'b0 || pll_div !== 5'd0 || busy !== 1'b0 || last_count !== 10'd0) $display("FAIL async_reset: got en=%b rb=%b div=%0d busy=%b cnt=%0d want 0 0 0 0 0", pll_enable, pll_resetb, pll_div, busy, last_count); else n_pass++;
        @(negedge clock);
        resetb = 1'b1;
        step(2);
    endtask

    task automatic test_random();
        logic        lk;
        logic        chk_lk;
        logic        gap;
        logic [4:0]  d;
        logic [25:0] t;
        int          expc, retry, miss, phase, off, n;
        for (int s = 0; s < 3; s++) begin
            d = 5'($urandom_range(2, 12));
            t = 26'($urandom);
            expc = int'(d) * 256 / 16;
            pulse_start(d, 1'b0, t);
            cfg_div = 5'($urandom);
            n_chk++; if (pll_div !== d || pll_ext_trim !== t) $display("FAIL rand_cfg%0d: got div=%0d trim=%h want %0d %h", s, pll_div, pll_ext_trim, d, t); else n_pass++;
            step(1040);
            retry = 0; miss = 0; phase = 0; chk_lk = 1'b0;
            for (int w = 0; w < 8 && phase != 2; w++) begin
                off = int'($urandom_range(0, 12)) - 6;
                n = expc + off;
                run_window(n, lk);
                if (chk_lk) begin
                    n_chk++; if (lk !== 1'b1) $display("FAIL rand_locked%0d_%0d: got %b want 1", s, w, lk); else n_pass++;
                end
                n_chk++; if (last_count !== 10'(n)) $display("FAIL rand_count%0d_%0d: got %0d want %0d", s, w, last_count, n); else n_pass++;
                gap = 1'b0;
                if (phase == 0) begin
                    if (off >= -2 && off <= 2) begin phase = 1; retry = 0; miss = 0; end
                    else begin retry++; if (retry == 3) phase = 2; else gap = 1'b1; end
                end else begin
                    if (off >= -2 && off <= 2) miss = 0;
                    else if (miss != 0) begin phase = 0; retry = 0; miss = 0; gap = 1'b1; end
                    else miss = 1;
                end
                if (phase == 2) begin
                    step(1);
                    n_chk++; if (fault !== 1'b1 || locked !== 1'b0) $display("FAIL rand_fault%0d: got f=%b l=%b want 1 0", s, fault, locked); else n_pass++;
                end else if (gap) begin
                    step(1);
                    n_chk++; if (locked !== 1'b0 || pll_resetb !== 1'b0) $display("FAIL rand_rehold%0d_%0d: got l=%b rb=%b want 0 0", s, w, locked, pll_resetb); else n_pass++;
                    step(1039);
                    chk_lk = 1'b0;
                end else begin
                    chk_lk = 1'b1;
                end
            end
            pulse_stop();
            n_chk++; if (fault !== 1'b0 || busy !== 1'b0) $display("FAIL rand_stop%0d: got f=%b busy=%b want 0 0", s, fault, busy); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_retry_fault();
        test_lock_loss();
        test_dco();
        test_bad_div();
        test_stop_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
